// File: rtl/adc_scan_arbiter_pkg.sv
// adc_scan_arbiter_pkg: shared FSM states, frame constants and command-bit helper
package adc_scan_arbiter_pkg;
  typedef enum logic [1:0] {IDLE, SETUP, SHIFT, GAP} state_e;
  localparam logic [4:0] FRAME_LEN = 5'd17;
  localparam logic [4:0] DATA_EDGE = 5'd8;
  localparam int RES_W = 10;
  // command bit driven during AD_CLK period b (1-based): start, sgl, D2, D1, D0, then zeros
  function automatic logic din_bit(input logic [4:0] b, input logic sgl, input logic [2:0] ch);
    return b == 5'd1 ? 1'b1 : b == 5'd2 ? sgl : b == 5'd3 ? ch[2] :
           b == 5'd4 ? ch[1] : b == 5'd5 ? ch[0] : 1'b0;
  endfunction
endpackage

// File: rtl/adc_scan_arbiter_rr_arbiter.sv
// adc_scan_arbiter_rr_arbiter: combinational round-robin pick, search starts just after i_ptr
module adc_scan_arbiter_rr_arbiter #(
  parameter int NREQ = 4
) (
  input  logic [NREQ-1:0]         i_req,
  input  logic [$clog2(NREQ)-1:0] i_ptr,
  output logic [NREQ-1:0]         o_gnt
);
  localparam int PW = $clog2(NREQ);
  // scan farthest-first so the nearest requester after i_ptr wins
  always_comb begin
    o_gnt = '0;
    for (int k = NREQ; k >= 1; k--)
      if (i_req[PW'((int'(i_ptr) + k) % NREQ)]) o_gnt = NREQ'(1) << PW'((int'(i_ptr) + k) % NREQ);
  end
endmodule

// File: rtl/adc_scan_arbiter.sv
// adc_scan_arbiter: round-robin shares one serial ADC among NREQ requesters, one 17-clock frame per grant
module adc_scan_arbiter
  import adc_scan_arbiter_pkg::*;
#(
  parameter int NREQ        = 4,
  parameter int SCLK_DIV    = 8,
  parameter int CS_HIGH_CYC = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NREQ-1:0]         req,
  input  logic [3*NREQ-1:0]       req_ch,
  input  logic [NREQ-1:0]         req_sgl,
  output logic [NREQ-1:0]         gnt,
  output logic                    done,
  output logic [$clog2(NREQ)-1:0] done_id,
  output logic [RES_W-1:0]        result,
  output logic                    busy,
  output logic                    AD_CLK,
  output logic                    CS,
  output logic                    DIN,
  input  logic                    DOUT
);
  localparam int PW = $clog2(NREQ);
  localparam int DW = $clog2(SCLK_DIV);
  localparam int GW = $clog2(CS_HIGH_CYC);
  state_e r_state, w_next;
  logic [NREQ-1:0] r_gnt, w_gnt;
  logic [PW-1:0] r_ptr, w_gnt_idx, r_done_id;
  logic [2:0] r_ch;
  logic r_sgl, r_sclk, r_din, r_done, w_div_end, w_last;
  logic [DW-1:0] r_div;
  logic [4:0] r_bit;
  logic [GW-1:0] r_gap;
  logic [RES_W-1:0] r_sr, r_result;

  adc_scan_arbiter_rr_arbiter #(.NREQ(NREQ)) u_rr (.i_req(req), .i_ptr(r_ptr), .o_gnt(w_gnt));

  always_comb begin
    w_gnt_idx = '0;
    for (int i = 0; i < NREQ; i++)
      if (w_gnt[i]) w_gnt_idx = PW'(i);
  end

  assign w_div_end = r_div == DW'(SCLK_DIV - 1);
  assign w_last    = w_div_end && r_sclk && r_bit == FRAME_LEN;

  // the IDLE cycle counts toward the CS-high gap, so GAP itself lasts one cycle less
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = |req ? SETUP : IDLE;
      SETUP:   w_next = w_div_end ? SHIFT : SETUP;
      SHIFT:   w_next = w_last ? GAP : SHIFT;
      default: w_next = r_gap == GW'(CS_HIGH_CYC - 2) ? IDLE : GAP;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_gnt <= '0; r_ptr <= PW'(NREQ - 1); r_ch <= '0; r_sgl <= 1'b0;
      r_div <= '0; r_bit <= '0; r_gap <= '0; r_sclk <= 1'b0; r_din <= 1'b0;
      r_done <= 1'b0; r_done_id <= '0; r_sr <= '0; r_result <= '0;
    end else begin
      r_done <= 1'b0;
      r_div  <= (r_state == IDLE || w_div_end) ? '0 : r_div + 1'b1;
      r_gap  <= (r_state == GAP) ? r_gap + 1'b1 : '0;
      if (r_state == IDLE && w_next == SETUP) begin
        r_gnt <= w_gnt;
        r_ptr <= w_gnt_idx;
        r_ch  <= req_ch[3*int'(w_gnt_idx) +: 3];
        r_sgl <= req_sgl[w_gnt_idx];
        r_bit <= 5'd1;
        r_din <= 1'b1;
      end
      if (r_state == SETUP && w_div_end) r_sclk <= 1'b1;
      if (r_state == SHIFT) begin
        // first clk of each high half is the ADC's rising edge; data bits start at edge 8
        if (r_sclk && r_div == '0 && r_bit >= DATA_EDGE) r_sr <= {r_sr[RES_W-2:0], DOUT};
        if (w_last) begin
          r_sclk <= 1'b0; r_din <= 1'b0; r_gnt <= '0;
          r_done <= 1'b1; r_result <= r_sr; r_done_id <= r_ptr;
        end else if (w_div_end) begin
          r_sclk <= !r_sclk;
          if (r_sclk) begin
            r_bit <= r_bit + 5'd1;
            r_din <= din_bit(r_bit + 5'd1, r_sgl, r_ch);
          end
        end
      end
    end

  assign CS      = !(r_state == SETUP || r_state == SHIFT);
  assign busy    = r_state != IDLE;
  assign AD_CLK  = r_sclk;
  assign DIN     = r_din;
  assign gnt     = r_gnt;
  assign done    = r_done;
  assign done_id = r_done_id;
  assign result  = r_result;
endmodule
